// File: rtl/pong_game_ctrl.sv
// Pong game controller: start/serve/play/pause/point/game-over sequencing.
// Ports: clk, rst_n (sync, active-low), frame_tick, start_btn, pause_btn,
//   pt_p1, pt_p2 in; ball_run, ball_center, serve_dir, p1_score, p2_score,
//   winner, state out.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       pt_p1,
    input  logic       pt_p2,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        PAUSED   = 3'd3,
        POINT    = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    localparam logic [7:0] DELAY = 8'(SERVE_DELAY);

    state_t     cur_state, nxt_state;
    logic [7:0] cnt, cnt_n;
    logic [3:0] p1_n, p2_n;
    logic [1:0] winner_n;
    logic       dir_n, run_n, center_n;
    logic       start_q, pause_q;
    // Blocks a start press that was already held through reset.
    logic       start_arm;
    logic       start_rise, pause_rise;

    assign start_rise = start_btn && !start_q && start_arm;
    assign pause_rise = pause_btn && !pause_q;
    assign state      = cur_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state   <= IDLE;
            cnt         <= 8'd0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            winner      <= 2'b00;
            serve_dir   <= 1'b0;
            ball_run    <= 1'b0;
            ball_center <= 1'b0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            start_arm   <= !start_btn;
        end else begin
            cur_state   <= nxt_state;
            cnt         <= cnt_n;
            p1_score    <= p1_n;
            p2_score    <= p2_n;
            winner      <= winner_n;
            serve_dir   <= dir_n;
            ball_run    <= run_n;
            ball_center <= center_n;
            start_q     <= start_btn;
            pause_q     <= pause_btn;
            start_arm   <= start_arm || !start_btn;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        cnt_n     = cnt;
        p1_n      = p1_score;
        p2_n      = p2_score;
        winner_n  = winner;
        dir_n     = serve_dir;
        unique case (cur_state)
            IDLE, GAMEOVER: begin
                if (start_rise) begin
                    nxt_state = SERVE;
                    cnt_n     = 8'd0;
                    p1_n      = 4'd0;
                    p2_n      = 4'd0;
                    winner_n  = 2'b00;
                    dir_n     = 1'b0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt + 8'd1 == DELAY)
                        nxt_state = PLAY;
                end
            end
            PLAY: begin
                if (pt_p1 && pt_p2) begin
                    // Simultaneous exits: replay the serve.
                    nxt_state = SERVE;
                    cnt_n     = 8'd0;
                end else if (pt_p1) begin
                    nxt_state = POINT;
                    dir_n     = 1'b0;
                    if (p1_score < WIN)
                        p1_n = p1_score + 4'd1;
                end else if (pt_p2) begin
                    nxt_state = POINT;
                    dir_n     = 1'b1;
                    if (p2_score < WIN)
                        p2_n = p2_score + 4'd1;
                end else if (pause_rise) begin
                    nxt_state = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_rise)
                    nxt_state = PLAY;
            end
            POINT: begin
                if (p1_score == WIN) begin
                    nxt_state = GAMEOVER;
                    winner_n  = 2'b01;
                end else if (p2_score == WIN) begin
                    nxt_state = GAMEOVER;
                    winner_n  = 2'b10;
                end else begin
                    nxt_state = SERVE;
                    cnt_n     = 8'd0;
                end
            end
            default: begin
                nxt_state = IDLE;
                cnt_n     = 8'd0;
                p1_n      = 4'd0;
                p2_n      = 4'd0;
                winner_n  = 2'b00;
                dir_n     = 1'b0;
            end
        endcase
        run_n    = (nxt_state == PLAY);
        // Centre pulse marks the first cycle of every serve.
        center_n = (nxt_state == SERVE) && (cur_state != SERVE);
    end

endmodule
